// File: rtl/mask_gen_512bit.sv
// mask_gen_512bit: builds a 512-bit contiguous range mask (bits L..R inclusive set),
// one SLICE_W-bit slice per clock into a shadow register, then publishes it atomically.
// Latency: trigger sampled at edge N -> o_done/o_mask valid after edge N+NSLICE.
// Backpressure: level handshake; i_trig held until o_done seen; DONE holds while i_trig=1.
//
// Ports:
//   i_clk                clock, all logic on rising edge
//   i_rst                synchronous active-high reset
//   i_trig               start request (level)
//   i_bound_index_left   left bound L (0..511)
//   i_bound_index_right  right bound R (0..511)
//   o_done               result valid / handshake acknowledge
//   o_mask               generated mask, bit i <-> index i
module mask_gen_512bit #(
  parameter int SLICE_W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_trig,
  input  logic [8:0]   i_bound_index_left,
  input  logic [8:0]   i_bound_index_right,
  output logic         o_done,
  output logic [511:0] o_mask
);

  localparam int NSLICE = 512 / SLICE_W;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [KW-1:0]  k;
  logic [8:0]     lat_l;
  logic [8:0]     lat_r;
  logic [511:0]   shadow;

  logic [9:0]         base;
  logic [SLICE_W-1:0] slice;
  logic [511:0]       shadow_nxt;

  // Slice k of the mask, from the latched bounds. Index math is 10 bits so
  // base+j never wraps and L>R naturally yields an empty slice.
  always_comb begin
    base       = 10'(k) * 10'(SLICE_W);
    slice      = '0;
    for (int j = 0; j < SLICE_W; j++) begin
      slice[j] = ((base + 10'(j)) >= {1'b0, lat_l}) &&
                 ((base + 10'(j)) <= {1'b0, lat_r});
    end
    // Shadow including the slice being computed this cycle, so the final
    // slice lands in o_mask on the same edge as the rest.
    shadow_nxt                     = shadow;
    shadow_nxt[base +: SLICE_W]    = slice;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      k      <= '0;
      lat_l  <= '0;
      lat_r  <= '0;
      shadow <= '0;
      o_done <= 1'b0;
      o_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_trig) begin
            lat_l <= i_bound_index_left;
            lat_r <= i_bound_index_right;
            k     <= '0;
            state <= BUILD;
          end
        end
        BUILD: begin
          shadow <= shadow_nxt;
          if (k == KW'(NSLICE - 1)) begin
            o_mask <= shadow_nxt;
            o_done <= 1'b1;
            k      <= '0;
            state  <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          // Requester must drop i_trig before another build can start.
          if (!i_trig) begin
            o_done <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mask_gen_512bit.sv
// tb_mask_gen_512bit: directed self-checking bench for mask_gen_512bit.
// Latency: not applicable (bench).
// Backpressure: requester model drops i_trig on the first cycle o_done is seen.
module tb_mask_gen_512bit;

  logic         clk;
  logic         rst;
  logic         trig;
  logic [8:0]   bl;
  logic [8:0]   br;
  logic         done;
  logic [511:0] mask;

  int total = 0;
  int bad   = 0;

  mask_gen_512bit #(.SLICE_W(32)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_trig              (trig),
    .i_bound_index_left  (bl),
    .i_bound_index_right (br),
    .o_done              (done),
    .o_mask              (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request, wait for o_done (bounded), optionally drop i_trig.
  // lat = edges after the trigger edge until o_done observed (99 on timeout).
  task automatic do_req(input int l, input int r, input bit drop, output int lat);
    bl   = 9'(l);
    br   = 9'(r);
    trig = 1'b1;
    tick();
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    if (!done) lat = 99;
    if (drop) trig = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    trig = 1'b0;
    bl   = '0;
    br   = '0;
    tick();
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++;
    if (mask !== '0) begin bad++; $display("FAIL reset_mask got=%h exp=0", mask); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    logic [511:0] exp;
    exp = '0;
    for (int i = 1; i <= 509; i++) exp[i] = 1'b1;
    do_req(1, 509, 1'b1, lat);
    total++;
    if (lat !== 16) begin bad++; $display("FAIL basic_latency got=%0d exp=16", lat); end
    total++;
    if (mask !== exp) begin bad++; $display("FAIL basic_mask got=%h exp=%h", mask, exp); end
    total++;
    if ({mask[511], mask[510], mask[509], mask[1], mask[0]} !== 5'b00110) begin
      bad++;
      $display("FAIL basic_edges got=%b exp=00110",
               {mask[511], mask[510], mask[509], mask[1], mask[0]});
    end
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL basic_done_fall got=%b exp=0", done); end
    total++;
    if (mask !== exp) begin bad++; $display("FAIL basic_mask_hold got=%h exp=%h", mask, exp); end
  endtask

  task automatic test_patterns();
    int lat;
    logic [511:0] exp;
    do_req(0, 511, 1'b1, lat);
    exp = '1;
    total++;
    if (mask !== exp || lat !== 16) begin
      bad++; $display("FAIL all_ones got=%h lat=%0d exp=%h lat=16", mask, lat, exp);
    end
    tick();
    do_req(100, 100, 1'b1, lat);
    exp = '0;
    exp[100] = 1'b1;
    total++;
    if (mask !== exp || lat !== 16) begin
      bad++; $display("FAIL single_bit got=%h lat=%0d exp=%h lat=16", mask, lat, exp);
    end
    tick();
    do_req(31, 32, 1'b1, lat);
    exp = '0;
    exp[31] = 1'b1;
    exp[32] = 1'b1;
    total++;
    if (mask !== exp || lat !== 16) begin
      bad++; $display("FAIL slice_cross got=%h lat=%0d exp=%h lat=16", mask, lat, exp);
    end
    tick();
  endtask

  // Prior mask on entry is bits 31,32 from test_patterns.
  task automatic test_bound_change();
    logic [511:0] prior;
    logic [511:0] exp;
    int held_bad;
    int n;
    prior = '0;
    prior[31] = 1'b1;
    prior[32] = 1'b1;
    exp = '0;
    for (int i = 10; i <= 20; i++) exp[i] = 1'b1;
    bl   = 9'd10;
    br   = 9'd20;
    trig = 1'b1;
    tick();
    bl = 9'd0;
    br = 9'd0;
    held_bad = 0;
    n = 0;
    while (!done && n < 40) begin
      if (mask !== prior) held_bad++;
      tick();
      n++;
    end
    total++;
    if (held_bad !== 0) begin bad++; $display("FAIL bc_mask_held got=%0d_changes exp=0", held_bad); end
    total++;
    if (n !== 16) begin bad++; $display("FAIL bc_latency got=%0d exp=16", n); end
    total++;
    if (mask !== exp) begin bad++; $display("FAIL bc_mask got=%h exp=%h", mask, exp); end
    trig = 1'b0;
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL bc_done_fall got=%b exp=0", done); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int stray;
    logic [511:0] exp;
    bl   = 9'd5;
    br   = 9'd400;
    trig = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    rst  = 1'b1;
    trig = 1'b0;
    tick();
    rst = 1'b0;
    total++;
    if (done !== 1'b0 || mask !== '0) begin
      bad++; $display("FAIL mid_reset got done=%b mask=%h exp done=0 mask=0", done, mask);
    end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 1'b0 || mask !== '0) stray++;
    end
    total++;
    if (stray !== 0) begin bad++; $display("FAIL mid_reset_trace got=%0d exp=0", stray); end
    do_req(7, 7, 1'b1, lat);
    exp = '0;
    exp[7] = 1'b1;
    total++;
    if (mask !== exp || lat !== 16) begin
      bad++; $display("FAIL post_reset got=%h lat=%0d exp=%h lat=16", mask, lat, exp);
    end
    tick();
  endtask

  task automatic test_inverted();
    int lat;
    do_req(300, 200, 1'b1, lat);
    total++;
    if (lat !== 16) begin bad++; $display("FAIL inv_latency got=%0d exp=16", lat); end
    total++;
    if (mask !== '0) begin bad++; $display("FAIL inv_mask got=%h exp=0", mask); end
    tick();
  endtask

  task automatic test_hold_high();
    int lat;
    int dropped;
    logic [511:0] exp1;
    logic [511:0] exp2;
    exp1 = '0;
    for (int i = 0; i <= 15; i++) exp1[i] = 1'b1;
    exp2 = '0;
    for (int i = 200; i <= 300; i++) exp2[i] = 1'b1;
    do_req(0, 15, 1'b0, lat);
    total++;
    if (mask !== exp1 || lat !== 16) begin
      bad++; $display("FAIL hold_first got=%h lat=%0d exp=%h lat=16", mask, lat, exp1);
    end
    bl = 9'd200;
    br = 9'd300;
    dropped = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done !== 1'b1 || mask !== exp1) dropped++;
    end
    total++;
    if (dropped !== 0) begin bad++; $display("FAIL hold_stay got=%0d exp=0", dropped); end
    trig = 1'b0;
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", done); end
    do_req(200, 300, 1'b1, lat);
    total++;
    if (mask !== exp2 || lat !== 16) begin
      bad++; $display("FAIL hold_retrig got=%h lat=%0d exp=%h lat=16", mask, lat, exp2);
    end
    tick();
  endtask

  initial begin
    rst  = 1'b1;
    trig = 1'b0;
    bl   = '0;
    br   = '0;
    test_reset();
    test_basic();
    test_patterns();
    test_bound_change();
    test_reset_mid();
    test_inverted();
    test_hold_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
